// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter for a shared tri-state bus. One requester at a time
//   gets the grant, for at most MAX_BURST consecutive cycles. Every release
//   is followed by one turnaround cycle with no grant, so two drivers never
//   overlap. All outputs come straight from flops.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : asynchronous reset, active low
//   req    : [NREQ] level request per requester
//   grant  : [NREQ] one-hot or zero, output enable of each requester's buffer
//   owner  : index of the granted requester, meaningful only when busy=1
//   busy   : high exactly when one grant bit is high
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant, waiting for any request
// GRANT | one requester drives the bus, burst counter running
// TURN  | one-cycle bus turnaround after a release, no grant

module bus_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req,
    output logic [NREQ-1:0]                         grant,
    output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] owner,
    output logic                                    busy
);

    localparam int OW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [OW-1:0]   ptr_q, ptr_n;
    logic [7:0]      cnt_q, cnt_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic [OW-1:0]   owner_q, owner_n;
    logic            busy_q, busy_n;

    logic            win_found;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   owner_inc;

    // Search ptr, ptr+1, ... modulo NREQ. Scanning the offsets from the far
    // end down lets the nearest requesting index overwrite the others.
    always_comb begin
        int sidx;
        win_found = 1'b0;
        win_idx   = '0;
        sidx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sidx = (int'(ptr_q) + k) % NREQ;
            if (req[sidx]) begin
                win_found = 1'b1;
                win_idx   = OW'(sidx);
            end
        end
    end

    assign owner_inc = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        grant_n = grant_q;
        owner_n = owner_q;
        busy_n  = busy_q;

        case (state_q)
            IDLE, TURN: begin
                if (win_found) begin
                    state_n          = GRANT;
                    grant_n          = '0;
                    grant_n[win_idx] = 1'b1;
                    owner_n          = win_idx;
                    busy_n           = 1'b1;
                    cnt_n            = 8'd1;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    cnt_n   = 8'd0;
                end
            end
            GRANT: begin
                // Release and burst expiry on the same edge collapse into
                // the one transition to TURN.
                if (!req[owner_q] || (cnt_q == 8'(MAX_BURST))) begin
                    state_n = TURN;
                    ptr_n   = owner_inc;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
                cnt_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            grant_q <= grant_n;
            owner_q <= owner_n;
            busy_q  <= busy_n;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: one instance with the default burst of 8 and one
// with a burst of 1, both compared each cycle against a behavioural model
// that only tracks "who holds the bus, for how long, and who is next".

module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    int m_wait  [2][4];
    int prev_g  [2];
    int run_len [2];

    bus_rr_arbiter #(.NREQ(4), .MAX_BURST(8)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .grant(grant_a), .owner(owner_a), .busy(busy_a)
    );

    bus_rr_arbiter #(.NREQ(4), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .grant(grant_b), .owner(owner_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_ptr[k]   = 0;
            prev_g[k]  = 0;
            run_len[k] = 0;
            for (int i = 0; i < 4; i++) m_wait[k][i] = 0;
        end
    endtask

    // Holder keeps the bus until it drops its request or has used its burst;
    // a released bus sits empty for one cycle; an empty bus goes to the first
    // requester at or after the pointer.
    task automatic model_edge(input int k, input logic [3:0] r, input int mb);
        int c;
        bit done;
        if (m_owner[k] >= 0) begin
            if (!r[m_owner[k]] || m_held[k] == mb) begin
                m_ptr[k]   = (m_owner[k] + 1) % 4;
                m_owner[k] = -1;
                m_held[k]  = 0;
            end else begin
                m_held[k]++;
            end
        end else begin
            done = 0;
            for (int j = 0; j < 4; j++) begin
                c = (m_ptr[k] + j) % 4;
                if (!done && r[c]) begin
                    m_owner[k] = c;
                    m_held[k]  = 1;
                    done       = 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic [3:0] r, input int mb);
        int expg;
        expg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
        chk($sformatf("grant%0d", k), int'(g), expg);
        chk($sformatf("busy%0d", k), int'(b), (expg != 0) ? 1 : 0);
        if (m_owner[k] >= 0) chk($sformatf("owner%0d", k), int'(o), m_owner[k]);
        chk($sformatf("onehot0_%0d", k), int'($onehot0(g)), 1);
        if (prev_g[k] != 0 && g != 0)
            chk($sformatf("gap_between_grants%0d", k), int'(g), prev_g[k]);
        if (g != 0 && int'(g) == prev_g[k]) run_len[k]++;
        else run_len[k] = (g != 0) ? 1 : 0;
        if (g != 0) chk($sformatf("burst_len%0d", k), int'(run_len[k] <= mb), 1);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && !g[i]) m_wait[k][i]++;
            else m_wait[k][i] = 0;
            if (r[i]) chk($sformatf("latency%0d_%0d", k, i), int'(m_wait[k][i] <= 4 * (mb + 1)), 1);
        end
        prev_g[k] = int'(g);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_edge(0, req_a, 8);
            model_edge(1, req_b, 1);
        end
        #1;
        check_dut(0, grant_a, owner_a, busy_a, req_a, 8);
        check_dut(1, grant_b, owner_b, busy_b, req_b, 1);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #1;
        model_reset();
        chk("rst_grant", int'(grant_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_owner", int'(owner_a), 0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int exp;
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #2;
        model_reset();

        // single continuous requester: 8 grant cycles, 1 gap, repeat
        do_reset();
        req_a = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            exp = ((c % 9) < 8) ? 1 : 0;
            chk("single_req_seq", int'(grant_a), exp);
            chk("single_req_busy", int'(busy_a), exp);
        end

        // all requesting: 0,1,2,3 each 8 cycles with a gap; burst 1 with 0101
        do_reset();
        req_a = 4'b1111;
        req_b = 4'b0101;
        for (int c = 0; c < 37; c++) begin
            step();
            exp = ((c % 9) < 8) ? (1 << ((c / 9) % 4)) : 0;
            chk("all_req_order", int'(grant_a), exp);
            case (c % 4)
                0: exp = 1;
                2: exp = 4;
                default: exp = 0;
            endcase
            chk("burst1_order", int'(grant_b), exp);
        end

        // owner 2 releases after 3 cycles with 0 and 3 waiting -> 3 wins
        do_reset();
        req_a = 4'b0100;
        step();
        chk("own2_grant", int'(grant_a), 4);
        req_a = 4'b1101;
        step();
        step();
        chk("own2_hold", int'(grant_a), 4);
        req_a = 4'b1001;
        step();
        chk("own2_turn", int'(grant_a), 0);
        step();
        chk("own2_next_is_3", int'(grant_a), 8);
        chk("own2_next_owner", int'(owner_a), 3);

        // reset between edges mid-grant drops the grant immediately
        do_reset();
        req_a = 4'b0001;
        step();
        step();
        chk("pre_async_grant", int'(grant_a), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_grant", int'(grant_a), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        chk("async_rst_owner", int'(owner_a), 0);
        step();
        rst   = 1'b1;
        req_a = 4'b0010;
        req_b = 4'b0000;
        step();
        chk("post_rst_grant", int'(grant_a), 2);

        // random traffic, slowly toggling request bits
        do_reset();
        req_a = 4'($urandom_range(0, 15));
        req_b = 4'($urandom_range(0, 15));
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(0, 5) == 0) req_b[i] = ~req_b[i];
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the tri-state bus; legal range 2..8.
REQ-002 Parameter MAX_BURST, default 8, maximum consecutive cycles one requester holds the grant; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 req  input  NREQ  bit i high = requester i wants to drive the bus; level-sensitive.
REQ-006 grant  output  NREQ  one-hot or zero; bit i drives the oe of requester i's tri-state buffer.
REQ-007 owner  output  clog2(NREQ) (min 1)  index of the granted requester; valid only when busy=1.
REQ-008 busy  output  1  high exactly when one grant bit is high.

Function
REQ-009 grant, owner and busy shall be registered outputs; no combinational path from req to any output.
REQ-010 The FSM shall have three states: IDLE, GRANT and TURN.
REQ-011 IDLE: grant=0, busy=0; if any req bit is high at a clock edge, move to GRANT at that edge with the round-robin winner.
REQ-012 Winner = first index j with req[j]=1, searching ptr, ptr+1, ... modulo NREQ; ptr is the round-robin pointer.
REQ-013 Grant latency: req high at edge k (bus idle) -> grant bit high from edge k onward, i.e. visible in cycle k+1.
REQ-014 GRANT: exactly one grant bit high, owner=its index, busy=1; burst counter starts at 1 on entry and increments each further GRANT cycle.
REQ-015 GRANT -> TURN when req[owner]=0 at an edge, or when the counter equals MAX_BURST (owner has held MAX_BURST cycles), whichever comes first.
REQ-016 On GRANT -> TURN, ptr shall become (owner+1) mod NREQ, so the releasing requester has lowest priority next.
REQ-017 TURN: exactly one cycle with grant=0, busy=0 (bus turnaround, no two drivers ever overlap).
REQ-018 TURN -> GRANT with the REQ-012 winner if any req bit is high at that edge; otherwise TURN -> IDLE.
REQ-019 A requester that is the only one requesting shall be re-granted after TURN; a continuous single requester sees MAX_BURST grant cycles, 1 gap cycle, repeated.
REQ-020 req changes on non-owner bits during GRANT shall not affect the grant.
REQ-021 Simultaneous owner release and burst expiry at one edge shall give the single TURN transition of REQ-015.
REQ-022 grant shall never have more than one bit high in any cycle, including reset entry and exit.
REQ-023 With MAX_BURST=1, every grant shall last exactly one cycle followed by one TURN cycle.

Reset
REQ-024 While rst=0: state=IDLE, grant=0, owner=0, busy=0, ptr=0, burst counter=0, all asynchronously.
REQ-025 Reset asserted during GRANT shall drop grant in the same cycle, without waiting for clk.
REQ-026 After rst deasserts, the first possible grant shall occur at the first rising edge with rst=1 and any req high.

Verification
REQ-027 Reset, then req=4'b0001 held -> grant=0001 for 8 cycles, 1 cycle 0000, then 0001 again; owner=0, busy mirrors grant.
REQ-028 Reset, req=4'b1111 held -> grant order 0001,0000,0010,0000,0100,0000,1000,0000,0001, each grant 8 cycles.
REQ-029 Owner 2 granted, drops req after 3 grant cycles while req[0],req[3] high -> one TURN cycle, then grant=1000 (ptr=3), not 0001.
REQ-030 rst pulled low mid-GRANT between clock edges -> grant=0000 and busy=0 before next edge; after release with req=0010 -> grant=0010 one edge later.
REQ-031 Random req stimulus for 10000 cycles -> assertions: grant one-hot-or-zero, at least one zero cycle between any two grants, no grant longer than MAX_BURST, every held request granted within NREQ*(MAX_BURST+1) cycles.
REQ-032 MAX_BURST=1, req=4'b0101 held -> grant 0001,0000,0100,0000 repeating.
